// File: rtl/cache_controller.sv
// Sequencing controller for a 2-line fully associative L1 in front of RAM.
// Serves hits locally; misses write back a dirty victim, then fill or allocate.
module cache_controller #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic              cpu_flush,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              ram_req,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WRITEBACK, FILL, FLUSH, DONE
    } state_t;

    state_t state, state_n;

    logic [1:0]        valid, dirty;
    logic              lru;
    logic [ADDR_W-1:0] tag  [2];
    logic [DATA_W-1:0] data [2];

    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              victim;
    logic              idx;
    logic              gap;

    logic [1:0] hit_vec;
    logic       hit;
    logic       hit_idx;
    logic       miss_idx;
    logic       victim_dirty;
    logic       line_dirty;

    assign hit_vec[0]   = valid[0] && (tag[0] == req_addr);
    assign hit_vec[1]   = valid[1] && (tag[1] == req_addr);
    assign hit          = |hit_vec;
    assign hit_idx      = hit_vec[1];
    assign miss_idx     = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru);
    assign victim_dirty = valid[miss_idx] && dirty[miss_idx];
    assign line_dirty   = valid[idx] && dirty[idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cpu_ready = (state == IDLE);
        cpu_done  = (state == DONE);
        ram_req   = 1'b0;
        ram_write = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (state)
            IDLE: begin
                if (cpu_req)        state_n = LOOKUP;
                else if (cpu_flush) state_n = FLUSH;
            end
            LOOKUP: begin
                if (hit)               state_n = DONE;
                else if (victim_dirty) state_n = WRITEBACK;
                else if (req_write)    state_n = DONE;
                else                   state_n = FILL;
            end
            WRITEBACK: begin
                ram_req   = 1'b1;
                ram_write = 1'b1;
                ram_addr  = tag[victim];
                ram_wdata = data[victim];
                if (ram_ack) state_n = req_write ? DONE : FILL;
            end
            FILL: begin
                // gap holds req low for one cycle after a write-back
                if (!gap) begin
                    ram_req  = 1'b1;
                    ram_addr = req_addr;
                    if (ram_ack) state_n = DONE;
                end
            end
            FLUSH: begin
                if (!gap) begin
                    if (line_dirty) begin
                        ram_req   = 1'b1;
                        ram_write = 1'b1;
                        ram_addr  = tag[idx];
                        ram_wdata = data[idx];
                    end
                    if (!line_dirty || ram_ack)
                        state_n = idx ? DONE : FLUSH;
                end
            end
            DONE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid     <= '0;
            dirty     <= '0;
            lru       <= 1'b0;
            tag[0]    <= '0;
            tag[1]    <= '0;
            data[0]   <= '0;
            data[1]   <= '0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            victim    <= 1'b0;
            idx       <= 1'b0;
            gap       <= 1'b0;
            cpu_rdata <= '0;
            cpu_hit   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_write <= cpu_write;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                    end else if (cpu_flush) begin
                        idx <= 1'b0;
                        gap <= 1'b0;
                    end
                end
                LOOKUP: begin
                    gap <= 1'b0;
                    if (hit) begin
                        lru     <= ~hit_idx;
                        cpu_hit <= 1'b1;
                        if (req_write) begin
                            data[hit_idx]  <= req_wdata;
                            dirty[hit_idx] <= 1'b1;
                        end else begin
                            cpu_rdata <= data[hit_idx];
                        end
                    end else begin
                        victim <= miss_idx;
                        if (!victim_dirty && req_write) begin
                            valid[miss_idx] <= 1'b1;
                            dirty[miss_idx] <= 1'b1;
                            tag[miss_idx]   <= req_addr;
                            data[miss_idx]  <= req_wdata;
                            lru             <= ~miss_idx;
                            cpu_hit         <= 1'b0;
                        end
                    end
                end
                WRITEBACK: begin
                    if (ram_ack) begin
                        dirty[victim] <= req_write;
                        if (req_write) begin
                            tag[victim]  <= req_addr;
                            data[victim] <= req_wdata;
                            lru          <= ~victim;
                            cpu_hit      <= 1'b0;
                        end else begin
                            gap <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    gap <= 1'b0;
                    if (!gap && ram_ack) begin
                        valid[victim] <= 1'b1;
                        dirty[victim] <= 1'b0;
                        tag[victim]   <= req_addr;
                        data[victim]  <= ram_rdata;
                        lru           <= ~victim;
                        cpu_rdata     <= ram_rdata;
                        cpu_hit       <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (gap) begin
                        gap <= 1'b0;
                    end else if (!line_dirty || ram_ack) begin
                        if (line_dirty) dirty[idx] <= 1'b0;
                        if (idx) begin
                            cpu_hit <= 1'b0;
                        end else begin
                            idx <= 1'b1;
                            gap <= line_dirty;
                        end
                    end
                end
                DONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a logging RAM responder.
// Timing counts are negedges after the acceptance edge until cpu_done.
module tb_cache_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_write = 1'b0;
    logic       cpu_flush = 1'b0;
    logic [7:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_ready, cpu_done, cpu_hit;
    logic [7:0] cpu_rdata;
    logic       ram_req, ram_write;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic       ram_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic       ack_en = 1'b1;
    logic [7:0] fill_data = '0;
    int         cyc = 0;
    int         nlog = 0;
    logic       lw [32];
    logic [7:0] la [32];
    logic [7:0] ld [32];
    int         lc [32];

    cache_controller #(.ADDR_W(8), .DATA_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_write (cpu_write),
        .cpu_flush (cpu_flush),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .cpu_hit   (cpu_hit),
        .ram_req   (ram_req),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (ram_ack) begin
            ram_ack = 1'b0;
        end else if (ram_req && ack_en) begin
            if (nlog < 32) begin
                lw[nlog] = ram_write;
                la[nlog] = ram_addr;
                ld[nlog] = ram_wdata;
                lc[nlog] = cyc;
                nlog = nlog + 1;
            end
            ram_rdata = fill_data;
            ram_ack   = 1'b1;
        end
    end

    task automatic do_req(input logic wr, input logic [7:0] a,
                          input logic [7:0] d);
        @(negedge clock);
        cpu_req   = 1'b1;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        @(negedge clock);
        cpu_req   = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clock);
        cpu_flush = 1'b1;
        @(negedge clock);
        cpu_flush = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!cpu_done && k < 50) begin
            @(negedge clock);
            k = k + 1;
        end
        if (!cpu_done) k = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++; if (cpu_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", cpu_ready); end
        n_cmp++; if (cpu_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", cpu_done); end
        n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata: got %h want 00", cpu_rdata); end
        n_cmp++; if (cpu_hit !== 1'b0) begin n_bad++; $display("FAIL rst_hit: got %b want 0", cpu_hit); end
        n_cmp++; if ({ram_req, ram_write} !== 2'b00) begin n_bad++; $display("FAIL rst_ram: got %b want 00", {ram_req, ram_write}); end
        n_cmp++; if ({ram_addr, ram_wdata} !== 16'h0) begin n_bad++; $display("FAIL rst_ramad: got %h want 0000", {ram_addr, ram_wdata}); end
        reset = 1'b0;
    endtask

    task automatic test_read_miss();
        int k, b;
        b = nlog;
        fill_data = 8'h05;
        do_req(1'b0, 8'h64, 8'h00);
        wait_done(k);
        n_cmp++; if (k !== 2) begin n_bad++; $display("FAIL rm_lat: got %0d want 2", k); end
        n_cmp++; if (cpu_hit !== 1'b0) begin n_bad++; $display("FAIL rm_hit: got %b want 0", cpu_hit); end
        n_cmp++; if (cpu_rdata !== 8'h05) begin n_bad++; $display("FAIL rm_rdata: got %h want 05", cpu_rdata); end
        n_cmp++; if (nlog !== b + 1) begin n_bad++; $display("FAIL rm_nram: got %0d want %0d", nlog, b + 1); end
        n_cmp++; if ({lw[b], la[b]} !== {1'b0, 8'h64}) begin n_bad++; $display("FAIL rm_ram: got %b/%h want 0/64", lw[b], la[b]); end
        n_cmp++; if (dut.lru !== 1'b1) begin n_bad++; $display("FAIL rm_lru: got %b want 1", dut.lru); end
    endtask

    task automatic test_read_hit();
        int k, b;
        b = nlog;
        do_req(1'b0, 8'h64, 8'h00);
        wait_done(k);
        n_cmp++; if (k !== 1) begin n_bad++; $display("FAIL rh_lat: got %0d want 1", k); end
        n_cmp++; if (cpu_hit !== 1'b1) begin n_bad++; $display("FAIL rh_hit: got %b want 1", cpu_hit); end
        n_cmp++; if (cpu_rdata !== 8'h05) begin n_bad++; $display("FAIL rh_rdata: got %h want 05", cpu_rdata); end
        n_cmp++; if (nlog !== b) begin n_bad++; $display("FAIL rh_nram: got %0d want %0d", nlog, b); end
    endtask

    task automatic test_write_alloc();
        int k, b;
        b = nlog;
        do_req(1'b1, 8'h65, 8'hAA);
        wait_done(k);
        n_cmp++; if (k !== 1) begin n_bad++; $display("FAIL wa_lat: got %0d want 1", k); end
        n_cmp++; if (cpu_hit !== 1'b0) begin n_bad++; $display("FAIL wa_hit: got %b want 0", cpu_hit); end
        n_cmp++; if (cpu_rdata !== 8'h05) begin n_bad++; $display("FAIL wa_rdata_held: got %h want 05", cpu_rdata); end
        do_req(1'b0, 8'h65, 8'h00);
        wait_done(k);
        n_cmp++; if (cpu_hit !== 1'b1) begin n_bad++; $display("FAIL wa_rd_hit: got %b want 1", cpu_hit); end
        n_cmp++; if (cpu_rdata !== 8'hAA) begin n_bad++; $display("FAIL wa_rd_data: got %h want AA", cpu_rdata); end
        n_cmp++; if (dut.lru !== 1'b0) begin n_bad++; $display("FAIL wa_lru: got %b want 0", dut.lru); end
        n_cmp++; if (nlog !== b) begin n_bad++; $display("FAIL wa_nram: got %0d want %0d", nlog, b); end
    endtask

    task automatic test_evict();
        int k, b;
        b = nlog;
        fill_data = 8'h01;
        do_req(1'b0, 8'h66, 8'h00);
        wait_done(k);
        n_cmp++; if (nlog !== b + 1) begin n_bad++; $display("FAIL ev66_nram: got %0d want %0d", nlog, b + 1); end
        n_cmp++; if ({lw[b], la[b]} !== {1'b0, 8'h66}) begin n_bad++; $display("FAIL ev66_ram: got %b/%h want 0/66", lw[b], la[b]); end
        n_cmp++; if ({cpu_hit, cpu_rdata} !== {1'b0, 8'h01}) begin n_bad++; $display("FAIL ev66_out: got %b/%h want 0/01", cpu_hit, cpu_rdata); end
        b = nlog;
        fill_data = 8'h02;
        do_req(1'b0, 8'h67, 8'h00);
        wait_done(k);
        n_cmp++; if (k !== 4) begin n_bad++; $display("FAIL ev67_lat: got %0d want 4", k); end
        n_cmp++; if (nlog !== b + 2) begin n_bad++; $display("FAIL ev67_nram: got %0d want %0d", nlog, b + 2); end
        n_cmp++; if ({lw[b], la[b], ld[b]} !== {1'b1, 8'h65, 8'hAA}) begin n_bad++; $display("FAIL ev67_wb: got %b/%h/%h want 1/65/AA", lw[b], la[b], ld[b]); end
        n_cmp++; if ({lw[b+1], la[b+1]} !== {1'b0, 8'h67}) begin n_bad++; $display("FAIL ev67_fill: got %b/%h want 0/67", lw[b+1], la[b+1]); end
        n_cmp++; if (lc[b+1] - lc[b] !== 2) begin n_bad++; $display("FAIL ev67_gap: got %0d want 2", lc[b+1] - lc[b]); end
        n_cmp++; if ({cpu_hit, cpu_rdata} !== {1'b0, 8'h02}) begin n_bad++; $display("FAIL ev67_out: got %b/%h want 0/02", cpu_hit, cpu_rdata); end
    endtask

    task automatic test_flush();
        int k, b;
        do_req(1'b1, 8'h66, 8'h33);
        wait_done(k);
        n_cmp++; if (cpu_hit !== 1'b1) begin n_bad++; $display("FAIL wh_hit: got %b want 1", cpu_hit); end
        b = nlog;
        do_flush();
        wait_done(k);
        n_cmp++; if (nlog !== b + 1) begin n_bad++; $display("FAIL fl1_nram: got %0d want %0d", nlog, b + 1); end
        n_cmp++; if ({lw[b], la[b], ld[b]} !== {1'b1, 8'h66, 8'h33}) begin n_bad++; $display("FAIL fl1_wb: got %b/%h/%h want 1/66/33", lw[b], la[b], ld[b]); end
        n_cmp++; if ({cpu_hit, cpu_rdata} !== {1'b0, 8'h02}) begin n_bad++; $display("FAIL fl1_out: got %b/%h want 0/02", cpu_hit, cpu_rdata); end
        n_cmp++; if (dut.lru !== 1'b1) begin n_bad++; $display("FAIL fl1_lru: got %b want 1", dut.lru); end
        b = nlog;
        do_flush();
        wait_done(k);
        n_cmp++; if (k !== 2) begin n_bad++; $display("FAIL fl2_lat: got %0d want 2", k); end
        n_cmp++; if (nlog !== b) begin n_bad++; $display("FAIL fl2_nram: got %0d want %0d", nlog, b); end
    endtask

    task automatic test_reset_mid();
        int k, b;
        ack_en = 1'b0;
        do_req(1'b0, 8'h68, 8'h00);
        @(negedge clock);
        n_cmp++; if ({ram_req, ram_write, ram_addr} !== {2'b10, 8'h68}) begin n_bad++; $display("FAIL mr_fill: got %b%b/%h want 10/68", ram_req, ram_write, ram_addr); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL mr_req: got %b want 0", ram_req); end
        n_cmp++; if (cpu_ready !== 1'b1) begin n_bad++; $display("FAIL mr_ready: got %b want 1", cpu_ready); end
        @(negedge clock);
        reset = 1'b0;
        ack_en = 1'b1;
        b = nlog;
        fill_data = 8'h09;
        do_req(1'b0, 8'h64, 8'h00);
        wait_done(k);
        n_cmp++; if (k !== 2) begin n_bad++; $display("FAIL mr_lat: got %0d want 2", k); end
        n_cmp++; if ({cpu_hit, cpu_rdata} !== {1'b0, 8'h09}) begin n_bad++; $display("FAIL mr_out: got %b/%h want 0/09", cpu_hit, cpu_rdata); end
        n_cmp++; if (nlog !== b + 1) begin n_bad++; $display("FAIL mr_nram: got %0d want %0d", nlog, b + 1); end
        n_cmp++; if ({lw[b], la[b]} !== {1'b0, 8'h64}) begin n_bad++; $display("FAIL mr_ram: got %b/%h want 0/64", lw[b], la[b]); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_alloc();
        test_evict();
        test_flush();
        test_reset_mid();
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
